serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a two-half-subtractor cell and a start/busy/done handshake.

module half_subtractor (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_b
);
  assign o_d = i_x ^ i_y;
  assign o_b = ~i_x & i_y;
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d1;
  logic             w_b1;
  logic             w_d;
  logic             w_b2;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell: (a_i - b_i) first, then subtract the running borrow.
  half_subtractor u_hs1 (.i_x(r_a[0]), .i_y(r_b[0]), .o_d(w_d1), .o_b(w_b1));
  half_subtractor u_hs2 (.i_x(w_d1),   .i_y(r_br),   .o_d(w_d),  .o_b(w_b2));

  assign w_br_next  = w_b1 | w_b2;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {w_d, (WIDTH-1)'(r_res >> 1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand/result shift registers are reset too, so no stale
      // operand bits survive an abort and every flop has a known value.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases, ignored
// start, back-to-back, mid-operation reset and randomized operands.

module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, bout, diff}; borrow-out is bit W of the widened difference.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    ov = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ r[W-1]);
    return {ov, r};
  endfunction

  // Issues one start, then follows busy until it drops (bounded), counting
  // busy cycles and any change of diff while busy. Returns on the done cycle.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] prev, output int busy_n, output int hold_err,
                        output logic got_done);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    busy_n = 0; hold_err = 0;
    while (busy === 1'b1 && busy_n < 4 * W) begin
      busy_n++;
      if (diff !== prev) hold_err++;
      @(negedge clk);
    end
    got_done = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #2;
    total++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b ovf=%b exp all 0",
               busy, done, diff, bout, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_directed(inout logic [W-1:0] prev);
    logic [W-1:0] ta [6] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'h80};
    logic [W-1:0] tb [6] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h7F};
    logic         tc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    logic [W+1:0] exp;
    int bn, he;
    logic gd;
    for (int i = 0; i < 6; i++) begin
      exp = model(ta[i], tb[i], tc[i]);
      run_op(ta[i], tb[i], tc[i], prev, bn, he, gd);
      total++;
      if (bn !== W || gd !== 1'b1 || he !== 0) begin
        bad++;
        $display("FAIL directed%0d_timing got busy_cycles=%0d done=%b hold_err=%0d exp %0d 1 0",
                 i, bn, gd, he, W);
      end
      total++;
      if ({ovf, bout, diff} !== exp) begin
        bad++;
        $display("FAIL directed%0d_result a=%h b=%h bin=%b got ovf=%b bout=%b diff=%h exp ovf=%b bout=%b diff=%h",
                 i, ta[i], tb[i], tc[i], ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
      end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00 || diff !== exp[W-1:0]) begin
        bad++;
        $display("FAIL directed%0d_done_pulse got done=%b busy=%b diff=%h exp 0 0 %h",
                 i, done, busy, diff, exp[W-1:0]);
      end
      prev = exp[W-1:0];
    end
  endtask

  task automatic test_back_to_back(inout logic [W-1:0] prev);
    int bn;
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bn = 0;
    for (int i = 1; i <= W; i++) begin
      if (busy === 1'b1) bn++;
      if (i == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    total++;
    if (bn !== W || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_timing got busy_cycles=%0d done=%b busy=%b exp %0d 1 0",
               bn, done, busy, W);
    end
    total++;
    if ({ovf, bout, diff} !== {2'b00, 8'h0F}) begin
      bad++;
      $display("FAIL ignore_start_result got ovf=%b bout=%b diff=%h exp 0 0 0f", ovf, bout, diff);
    end
    a = 8'h20; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10 || diff !== 8'h0F) begin
      bad++;
      $display("FAIL back_to_back_start got busy=%b done=%b diff=%h exp 1 0 0f", busy, done, diff);
    end
    bn = 0;
    while (busy === 1'b1 && bn < 4 * W) begin
      bn++;
      @(negedge clk);
    end
    total++;
    if (bn !== W || done !== 1'b1 || {ovf, bout, diff} !== 10'h000) begin
      bad++;
      $display("FAIL back_to_back_result got busy_cycles=%0d done=%b ovf=%b bout=%b diff=%h exp %0d 1 0 0 00",
               bn, done, ovf, bout, diff, W);
    end
    prev = 8'h00;
  endtask

  task automatic test_mid_reset(inout logic [W-1:0] prev);
    logic [W+1:0] exp;
    int bn, he;
    logic gd;
    run_op(8'h03, 8'h05, 1'b0, prev, bn, he, gd);
    @(negedge clk);
    a = 8'h42; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got busy=%b done=%b diff=%h bout=%b ovf=%b exp all 0",
               busy, done, diff, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    exp = model(8'h42, 8'h11, 1'b0);
    run_op(8'h42, 8'h11, 1'b0, 8'h00, bn, he, gd);
    total++;
    if (bn !== W || gd !== 1'b1 || he !== 0 || {ovf, bout, diff} !== exp) begin
      bad++;
      $display("FAIL after_reset_op got busy_cycles=%0d done=%b hold_err=%0d ovf=%b bout=%b diff=%h exp %0d 1 0 %b %b %h",
               bn, gd, he, ovf, bout, diff, W, exp[W+1], exp[W], exp[W-1:0]);
    end
    prev = exp[W-1:0];
  endtask

  task automatic test_random(inout logic [W-1:0] prev);
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W+1:0] exp;
    int bn, he;
    logic gd;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp = model(ra, rb, rc);
      run_op(ra, rb, rc, prev, bn, he, gd);
      total++;
      if (bn !== W || gd !== 1'b1 || he !== 0) begin
        bad++;
        $display("FAIL random%0d_timing got busy_cycles=%0d done=%b hold_err=%0d exp %0d 1 0",
                 i, bn, gd, he, W);
      end
      total++;
      if ({ovf, bout, diff} !== exp) begin
        bad++;
        $display("FAIL random%0d_result a=%h b=%h bin=%b got ovf=%b bout=%b diff=%h exp ovf=%b bout=%b diff=%h",
                 i, ra, rb, rc, ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
      end
      prev = exp[W-1:0];
    end
  endtask

  initial begin
    logic [W-1:0] prev;
    clk  = 1'b0;
    prev = '0;
    test_reset();
    test_directed(prev);
    test_back_to_back(prev);
    test_mid_reset(prev);
    test_random(prev);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
